// File: rtl/lock_rst_pkg.sv
// Shared types for the PLL-lock reset sequencer: FSM state encoding and loss-counter width.
package lock_rst_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/lock_rst_seq_sync_ff.sv
// Multi-stage flop synchroniser for a single asynchronous bit; cleared by synchronous rst.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/lock_rst_seq.sv
// Holds downstream logic in reset until PLL lock is synchronised, qualified and held.
// Optional lock-loss counter enabled by defining LOCK_RST_SEQ_LOSS_CNT_EN.
module lock_rst_seq
   import lock_rst_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 256,
   parameter int HOLD_CYCLES   = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pll_lock,
   output logic                  rst_n_out,
   output logic                  ready,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

   localparam int MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

   logic             lock_s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rst_n_q, rst_n_d;
   logic             ready_q, ready_d;

   sync_ff #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (pll_lock),
      .q  (lock_s)
   );

   // Outputs follow the registered state, so they lag it by one edge and never see pll_lock combinationally.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rst_n_d = (state_q == RUN);
      ready_d = (state_q == RUN);
      case (state_q)
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = STABLE;
               cnt_d   = '0;
            end
         end
         STABLE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
         rst_n_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rst_n_q <= rst_n_d;
         ready_q <= ready_d;
      end
   end

   assign rst_n_out = rst_n_q;
   assign ready     = ready_q;

`ifdef LOCK_RST_SEQ_LOSS_CNT_EN
   logic                  lost;
   logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

   // Every exit to WAIT_LOCK from a qualifying state is a loss; the count saturates.
   always_comb begin
      lost       = (state_q != WAIT_LOCK) && (state_d == WAIT_LOCK);
      loss_cnt_d = loss_cnt_q;
      if (lost && (loss_cnt_q != '1)) begin
         loss_cnt_d = loss_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         loss_cnt_q <= '0;
      end else begin
         loss_cnt_q <= loss_cnt_d;
      end
   end

   assign lock_loss_cnt = loss_cnt_q;
`else
   assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_lock_rst_seq.sv
// Directed bench for lock_rst_seq with SYNC_STAGES=2, STABLE_CYCLES=4, HOLD_CYCLES=8.
module tb_lock_rst_seq;

   logic       clk;
   logic       rst;
   logic       pll_lock;
   logic       rst_n_out;
   logic       ready;
   logic [7:0] lock_loss_cnt;

   int tests_run;
   int tests_failed;

   lock_rst_seq #(
      .SYNC_STAGES  (2),
      .STABLE_CYCLES(4),
      .HOLD_CYCLES  (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pll_lock     (pll_lock),
      .rst_n_out    (rst_n_out),
      .ready        (ready),
      .lock_loss_cnt(lock_loss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic rst;
      logic lock;
      int   cycles;
      logic rst_n;
      logic rdy;
      int   loss;
   } vec_t;

   vec_t vecs[23];

   function automatic int exp_loss(input int n);
      int r;
`ifdef LOCK_RST_SEQ_LOSS_CNT_EN
      r = (n > 255) ? 255 : n;
`else
      r = 0;
`endif
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   initial begin
      int losses;
      logic bad_out;
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      pll_lock     = 1'b0;

      // rst, lock, cycles, rst_n, ready, losses
      vecs[0]  = '{1'b1, 1'b1,  3, 1'b0, 1'b0, 0};
      vecs[1]  = '{1'b0, 1'b1, 15, 1'b0, 1'b0, 0};
      vecs[2]  = '{1'b0, 1'b1,  1, 1'b1, 1'b1, 0};
      vecs[3]  = '{1'b0, 1'b1,  5, 1'b1, 1'b1, 0};
      vecs[4]  = '{1'b0, 1'b0,  2, 1'b1, 1'b1, 0};
      vecs[5]  = '{1'b0, 1'b0,  1, 1'b1, 1'b1, 1};
      vecs[6]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1};
      vecs[7]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1};
      vecs[8]  = '{1'b0, 1'b1, 15, 1'b0, 1'b0, 1};
      vecs[9]  = '{1'b0, 1'b1,  1, 1'b1, 1'b1, 1};
      vecs[10] = '{1'b1, 1'b1,  1, 1'b0, 1'b0, 0};
      vecs[11] = '{1'b1, 1'b1,  1, 1'b0, 1'b0, 0};
      vecs[12] = '{1'b0, 1'b1,  4, 1'b0, 1'b0, 0};
      vecs[13] = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 0};
      vecs[14] = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 0};
      vecs[15] = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1};
      vecs[16] = '{1'b0, 1'b1, 13, 1'b0, 1'b0, 1};
      vecs[17] = '{1'b0, 1'b1,  1, 1'b1, 1'b1, 1};
      vecs[18] = '{1'b1, 1'b1,  2, 1'b0, 1'b0, 0};
      vecs[19] = '{1'b0, 1'b1, 12, 1'b0, 1'b0, 0};
      vecs[20] = '{1'b1, 1'b1,  1, 1'b0, 1'b0, 0};
      vecs[21] = '{1'b0, 1'b1, 15, 1'b0, 1'b0, 0};
      vecs[22] = '{1'b0, 1'b1,  1, 1'b1, 1'b1, 0};

      for (int i = 0; i < 23; i++) begin
         rst      = vecs[i].rst;
         pll_lock = vecs[i].lock;
         tick(vecs[i].cycles);
         check("rst_n_out", i, {7'd0, rst_n_out}, {7'd0, vecs[i].rst_n});
         check("ready", i, {7'd0, ready}, {7'd0, vecs[i].rdy});
         check("lock_loss_cnt", i, lock_loss_cnt, 8'(exp_loss(vecs[i].loss)));
      end

      // Repeated short qualifications cut off in STABLE: one loss per 6-cycle period.
      rst      = 1'b1;
      pll_lock = 1'b0;
      tick(3);
      rst     = 1'b0;
      losses  = 0;
      bad_out = 1'b0;
      for (int n = 1; n <= 300; n++) begin
         pll_lock = 1'b1;
         for (int k = 0; k < 3; k++) begin
            tick(1);
            if (rst_n_out !== 1'b0 || ready !== 1'b0) bad_out = 1'b1;
         end
         pll_lock = 1'b0;
         for (int k = 0; k < 3; k++) begin
            tick(1);
            if (rst_n_out !== 1'b0 || ready !== 1'b0) bad_out = 1'b1;
         end
         losses++;
         if (n == 1 || n == 254 || n == 255 || n == 256 || n == 300) begin
            check("sat_loss_cnt", n, lock_loss_cnt, 8'(exp_loss(losses)));
         end
      end
      check("sat_outputs_low", 0, {7'd0, bad_out}, 8'd0);

      // No lock at all for a long time.
      rst = 1'b1;
      tick(2);
      rst     = 1'b0;
      bad_out = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         tick(1);
         if (rst_n_out !== 1'b0 || ready !== 1'b0 || lock_loss_cnt !== 8'd0) bad_out = 1'b1;
      end
      check("idle_outputs_low", 0, {7'd0, bad_out}, 8'd0);
      check("idle_state", 0, {6'd0, dut.state_q}, 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
